// File: rtl/top_fetch.sv
// -----------------------------------------------------------------------------
// top_fetch -- instruction fetch unit with in-order memory interface,
// credit-limited instruction buffer and redirect/flush handling.
//
// Fetch requests go out on imem_req/imem_addr. Each accepted request
// (imem_req && imem_ready) records its PC in an in-flight queue. Memory
// responses come back in request order, at least one cycle after acceptance.
// Each response is paired with its queued PC and written into the instruction
// buffer. The buffer head is presented to decode on instr/instr_pc/instr_valid.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// edge where both valid and ready are high. A valid/address that is raised
// stays stable until it is transferred. The only exceptions are redirect and
// rst, which may withdraw it.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   imem_req/imem_addr  fetch request valid / word-aligned byte address
//   imem_ready          memory accepts the request this cycle
//   imem_rvalid/rdata   in-order response valid / instruction word
//   instr/instr_pc      buffer head word and its PC (0 when buffer empty)
//   instr_valid/ready   buffer head valid / decode consumes head
//   redirect/_pc        taken branch: flush buffer, refetch at target & ~3
//   dbg_flush           debug view of the FSM: 1 while in FLUSH
// -----------------------------------------------------------------------------
module top_fetch #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  dbg_flush
);

  localparam int unsigned           PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned           CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]        DEPTH_C  = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0]      LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Circular pointer increment; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;

  // Instruction buffer (decoded-side FIFO)
  logic [DATA_WIDTH-1:0] buf_instr_q [DEPTH];
  logic [DATA_WIDTH-1:0] buf_instr_d [DEPTH];
  logic [DATA_WIDTH-1:0] buf_pc_q    [DEPTH];
  logic [DATA_WIDTH-1:0] buf_pc_d    [DEPTH];
  logic [PTR_W-1:0]      buf_head_q, buf_head_d;
  logic [PTR_W-1:0]      buf_tail_q, buf_tail_d;
  logic [CNT_W-1:0]      occ_q, occ_d;

  // In-flight PC queue: one entry per live (non-stale) outstanding request
  logic [DATA_WIDTH-1:0] ifq_pc_q [DEPTH];
  logic [DATA_WIDTH-1:0] ifq_pc_d [DEPTH];
  logic [PTR_W-1:0]      ifq_head_q, ifq_head_d;
  logic [PTR_W-1:0]      ifq_tail_q, ifq_tail_d;
  logic [CNT_W-1:0]      out_q, out_d;

  // Responses still owed by memory for requests made before a redirect
  logic [CNT_W-1:0]      stale_q, stale_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic [CNT_W:0]        in_use;
  logic                  credit_ok;
  logic                  accept;
  logic                  rsp_hit;
  logic                  pop;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  unused_low_bits;

  // Credits cover both buffered and in-flight instructions, so a response
  // always finds a free buffer slot and never needs back-pressure. Because
  // a response only moves a credit from in-flight to buffered, the sum cannot
  // rise without an accept. That keeps a raised request stable until it is taken.
  assign in_use    = {1'b0, occ_q} + {1'b0, out_q};
  assign credit_ok = (in_use < DEPTH_C);

  assign imem_req  = !rst && (state_q == ST_RUN) && credit_ok;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;

  // A response is ours only in RUN with something outstanding. Responses with
  // nothing outstanding belong to requests issued before a reset.
  assign rsp_hit   = imem_rvalid && (out_q != '0);

  assign instr_valid = (occ_q != '0);
  assign instr       = instr_valid ? buf_instr_q[buf_head_q] : '0;
  assign instr_pc    = instr_valid ? buf_pc_q[buf_head_q]    : '0;
  assign pop         = instr_valid && instr_ready;

  assign redirect_target = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];

  assign dbg_flush = (state_q == ST_FLUSH);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_head_d  = buf_head_q;
    buf_tail_d  = buf_tail_q;
    occ_d       = occ_q;
    ifq_pc_d    = ifq_pc_q;
    ifq_head_d  = ifq_head_q;
    ifq_tail_d  = ifq_tail_q;
    out_d       = out_q;
    stale_d     = stale_q;

    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          // Everything in flight becomes stale. That includes a request
          // accepted this very cycle. It excludes a response arriving now,
          // which is simply dropped.
          stale_d    = out_q - CNT_W'(rsp_hit) + CNT_W'(accept);
          fetch_pc_d = redirect_target;
          occ_d      = '0;
          out_d      = '0;
          buf_head_d = '0;
          buf_tail_d = '0;
          ifq_head_d = '0;
          ifq_tail_d = '0;
          state_d    = (stale_d != '0) ? ST_FLUSH : ST_RUN;
        end else begin
          if (accept) begin
            ifq_pc_d[ifq_tail_q] = fetch_pc_q;
            ifq_tail_d           = ptr_inc(ifq_tail_q);
            fetch_pc_d           = fetch_pc_q + PC_STEP;
          end
          if (rsp_hit) begin
            buf_instr_d[buf_tail_q] = imem_rdata;
            buf_pc_d[buf_tail_q]    = ifq_pc_q[ifq_head_q];
            buf_tail_d              = ptr_inc(buf_tail_q);
            ifq_head_d              = ptr_inc(ifq_head_q);
          end
          if (pop) begin
            buf_head_d = ptr_inc(buf_head_q);
          end
          out_d = out_q + CNT_W'(accept) - CNT_W'(rsp_hit);
          occ_d = occ_q + CNT_W'(rsp_hit) - CNT_W'(pop);
        end
      end

      ST_FLUSH: begin
        // No requests go out here, and the buffer is already empty. Each
        // response drains one stale slot. A further redirect only moves the
        // restart address.
        if (imem_rvalid && (stale_q != '0)) begin
          stale_d = stale_q - CNT_W'(1);
        end
        if (redirect) begin
          fetch_pc_d = redirect_target;
        end
        if (stale_d == '0) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      fetch_pc_q  <= RESET_PC;
      buf_instr_q <= '{default: '0};
      buf_pc_q    <= '{default: '0};
      buf_head_q  <= '0;
      buf_tail_q  <= '0;
      occ_q       <= '0;
      ifq_pc_q    <= '{default: '0};
      ifq_head_q  <= '0;
      ifq_tail_q  <= '0;
      out_q       <= '0;
      stale_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_head_q  <= buf_head_d;
      buf_tail_q  <= buf_tail_d;
      occ_q       <= occ_d;
      ifq_pc_q    <= ifq_pc_d;
      ifq_head_q  <= ifq_head_d;
      ifq_tail_q  <= ifq_tail_d;
      out_q       <= out_d;
      stale_q     <= stale_d;
    end
  end

endmodule

// File: tb/tb_top_fetch.sv
// -----------------------------------------------------------------------------
// tb_top_fetch -- self-checking bench for top_fetch.
// An in-order memory model with programmable latency drives the DUT.
// A scoreboard holds the PCs that were fetched but not yet consumed. Any
// redirect or reset clears it. Checks:
//   - fetched addresses follow the program-order PC, advancing by 4 and wrapping
//   - every consumed instruction matches the scoreboard head in PC and data
//   - no more than DEPTH instructions are ever fetched and not yet consumed
//   - the request and the buffer head hold stable while stalled
//   - the post-redirect and post-reset cycles behave as required
// -----------------------------------------------------------------------------
module tb_top_fetch;

  localparam int          W      = 32;
  localparam int          DEPTH  = 2;
  localparam logic [W-1:0] RST_PC = 32'h0000_0040;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk;
  logic         rst;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ready;
  logic         imem_rvalid;
  logic [W-1:0] imem_rdata;
  logic [W-1:0] instr;
  logic [W-1:0] instr_pc;
  logic         instr_valid;
  logic         instr_ready;
  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic         dbg_flush;

  top_fetch #(.DATA_WIDTH(W), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dbg_flush   (dbg_flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and memory model state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] addr;
    int           due;
  } mem_t;

  mem_t         mem_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_fetch;
  int           lat_lo, lat_hi;
  int           last_due;
  int           cyc;
  int           n_total, n_bad;
  int           n_acc, n_pop;

  // Values sampled from the DUT in the current cycle, and carried to the next
  logic         s_req, s_valid, s_flush;
  logic [W-1:0] s_addr, s_instr, s_pc;
  logic [W-1:0] p_addr, p_instr, p_pc;
  logic         hold_chk, flush_chk, ihold_chk, post_rst_chk;

  function automatic logic [W-1:0] instr_of(input logic [W-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0001;
  endfunction

  task automatic chk_word(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle. Inputs change at the falling edge. Outputs are
  // sampled 1 time unit later, and the handshakes they imply take effect at
  // the next rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic ir, input logic mr, input logic rd,
                      input logic [W-1:0] rpc, input logic rs);
    logic acc, pop;
    int   due;
    mem_t m;
    @(negedge clk);
    rst         = rs;
    imem_ready  = mr;
    instr_ready = ir;
    redirect    = rd;
    redirect_pc = rpc;
    if (rs) begin
      mem_q.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_instr = instr;
    s_pc    = instr_pc;
    s_flush = dbg_flush;

    if (rs) begin
      chk_bit("req_in_reset", s_req, 1'b0);
      exp_q.delete();
      exp_fetch = RST_PC;
    end else begin
      if (post_rst_chk) begin
        chk_bit ("post_rst_req",   s_req,   1'b1);
        chk_word("post_rst_addr",  s_addr,  RST_PC);
        chk_bit ("post_rst_valid", s_valid, 1'b0);
      end
      if (hold_chk) begin
        chk_bit ("req_hold",  s_req,  1'b1);
        chk_word("addr_hold", s_addr, p_addr);
      end
      if (flush_chk) chk_bit("valid_after_redirect", s_valid, 1'b0);
      if (ihold_chk) begin
        chk_bit ("instr_valid_hold", s_valid, 1'b1);
        chk_word("instr_hold",       s_instr, p_instr);
        chk_word("instr_pc_hold",    s_pc,    p_pc);
      end

      acc = s_req && mr;
      pop = s_valid && ir && !rd;

      if (pop) begin
        n_pop++;
        chk_bit("pop_expected", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
          chk_word("instr_pc", s_pc, exp_q[0]);
          chk_word("instr",    s_instr, instr_of(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (acc) begin
        n_acc++;
        chk_word("fetch_addr", s_addr, exp_fetch);
        chk_bit ("credit", (exp_q.size() < DEPTH), 1'b1);
        exp_fetch = exp_fetch + 32'd4;
        due = cyc + $urandom_range(lat_hi, lat_lo);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        m.addr = s_addr;
        m.due  = due;
        mem_q.push_back(m);
        if (!rd) exp_q.push_back(s_addr);
      end
      if (rd) begin
        exp_q.delete();
        exp_fetch = {rpc[W-1:2], 2'b00};
      end
    end

    p_addr       = s_addr;
    p_instr      = s_instr;
    p_pc         = s_pc;
    hold_chk     = !rs && s_req && !mr && !rd;
    flush_chk    = !rs && rd;
    ihold_chk    = !rs && s_valid && !ir && !rd;
    post_rst_chk = rs;
    cyc++;
  endtask

  task automatic do_reset(input int lat);
    lat_lo = lat;
    lat_hi = lat;
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  // Run with decode ready until the head is valid, then check its PC.
  task automatic wait_valid(input string nm, input logic [W-1:0] exp_pc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      if (s_valid) begin
        found = 1'b1;
        chk_word(nm, s_pc, exp_pc);
      end
    end
    chk_bit("wait_valid_in_time", found, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Zero-wait vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         exp_req;
    logic [W-1:0] exp_addr;
    logic         exp_valid;
    logic [W-1:0] exp_pc;
  } vec_t;

  vec_t vecs[9];
  int   base_acc, base_pop;

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    n_total = 0; n_bad = 0; n_acc = 0; n_pop = 0; cyc = 0; last_due = 0;
    exp_fetch = RST_PC; lat_lo = 1; lat_hi = 1;
    hold_chk = 0; flush_chk = 0; ihold_chk = 0; post_rst_chk = 0;
    p_addr = '0; p_instr = '0; p_pc = '0;

    // Latency 1, always ready, DEPTH 2. Credits count buffered plus in-flight
    // instructions, so each new fetch waits for a slot to free up.
    vecs[0] = '{1'b1, RST_PC + 32'h00, 1'b0, '0};
    vecs[1] = '{1'b1, RST_PC + 32'h04, 1'b0, '0};
    vecs[2] = '{1'b0, '0,              1'b1, RST_PC + 32'h00};
    vecs[3] = '{1'b1, RST_PC + 32'h08, 1'b1, RST_PC + 32'h04};
    vecs[4] = '{1'b1, RST_PC + 32'h0C, 1'b0, '0};
    vecs[5] = '{1'b0, '0,              1'b1, RST_PC + 32'h08};
    vecs[6] = '{1'b1, RST_PC + 32'h10, 1'b1, RST_PC + 32'h0C};
    vecs[7] = '{1'b1, RST_PC + 32'h14, 1'b0, '0};
    vecs[8] = '{1'b0, '0,              1'b1, RST_PC + 32'h10};

    do_reset(1);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      chk_bit("tbl_req", s_req, vecs[i].exp_req);
      if (vecs[i].exp_req) chk_word("tbl_addr", s_addr, vecs[i].exp_addr);
      chk_bit("tbl_valid", s_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        chk_word("tbl_pc",    s_pc,    vecs[i].exp_pc);
        chk_word("tbl_instr", s_instr, instr_of(vecs[i].exp_pc));
      end
    end

    // Decode stalled for 10 cycles: only DEPTH fetches may go out
    do_reset(1);
    base_acc = n_acc;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk_word("stall_requests", W'(n_acc - base_acc), W'(2));
    chk_bit ("stall_valid", s_valid, 1'b1);
    chk_word("stall_pc",    s_pc,    RST_PC);
    base_pop = n_pop;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk_bit("stall_resume_rate", (n_pop - base_pop) >= 12, 1'b1);

    // Redirect with two requests outstanding, latency 3
    do_reset(3);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    chk_bit("redir_req_full", s_req, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk_bit("flush_state_1", s_flush, 1'b1);
    chk_bit("flush_req_1",   s_req,   1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk_bit("flush_state_2", s_flush, 1'b1);
    chk_bit("flush_req_2",   s_req,   1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk_bit ("flush_exit",      s_flush, 1'b0);
    chk_bit ("redir_req",       s_req,   1'b1);
    chk_word("redir_addr",      s_addr,  32'h0000_0100);
    wait_valid("redir_first_pc", 32'h0000_0100);

    // Redirect to an unaligned target in the same cycle as a response
    do_reset(1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0203, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk_bit ("align_req",   s_req,   1'b1);
    chk_word("align_addr",  s_addr,  32'h0000_0200);
    chk_bit ("align_flush", s_flush, 1'b0);
    wait_valid("align_first_pc", 32'h0000_0200);

    // Reset with a full buffer
    do_reset(1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk_bit("full_before_rst", s_valid, 1'b1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk_bit ("rst_valid", s_valid, 1'b0);
    chk_word("rst_addr",  s_addr,  RST_PC);
    wait_valid("rst_first_pc", RST_PC);

    // PC wrap at the top of the address space. The fetch accepted in the
    // redirect cycle is stale and must be dropped.
    do_reset(2);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    wait_valid("wrap_pc_0", 32'hFFFF_FFF8);
    wait_valid("wrap_pc_1", 32'hFFFF_FFFC);
    wait_valid("wrap_pc_2", 32'h0000_0000);

    // Random traffic
    lat_lo = 1;
    lat_hi = 4;
    do_reset(1);
    lat_hi = 4;
    base_pop = n_pop;
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0, rpc, $urandom_range(0, 299) == 0);
    end
    chk_bit("random_progress", (n_pop - base_pop) >= 100, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
